serial_crc_accum: RTL and testbench

- Bit-serial CRC accumulator placed directly downstream of the gate-level XOR cell library.
- Consumes a framed serial bit stream through a valid/ready handshake and folds each bit into a CRC register via an LFSR.
- Feedback taps are built from XOR cells.
- At frame end it presents the CRC with a one-cycle valid pulse to the link/checker stage.

---
 rtl/serial_crc_accum_pkg.sv | 21 ++
 rtl/serial_crc_accum_if.sv | 31 +++
 rtl/serial_crc_accum_crc_lfsr_step.sv | 37 +++
 rtl/xor2_cell.sv | 10 +
 rtl/serial_crc_accum.sv | 95 +++++++++
 tb/tb_serial_crc_accum.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_crc_accum_pkg.sv
// Shared definitions for the bit-serial CRC accumulator.
// Holds the FSM state encoding and the default CRC-8 configuration.
package serial_crc_accum_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_FRAME_LEN = 16;
    localparam logic [7:0]  DEF_POLY      = 8'h07;
    localparam logic [7:0]  DEF_INIT      = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a counter able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_crc_accum_if.sv
// Serial bit stream in, CRC result out.
//   start_in      frame start request
//   bit_in        serial data bit, MSB-first
//   bit_valid_in  bit_in valid this cycle
//   bit_ready_out accumulator accepts a bit this cycle
//   busy_out      frame in progress
//   crc_out       current/final CRC register value
//   crc_valid_out one-cycle pulse marking the final frame CRC
interface serial_crc_accum_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start_in;
    logic             bit_in;
    logic             bit_valid_in;
    logic             bit_ready_out;
    logic             busy_out;
    logic [WIDTH-1:0] crc_out;
    logic             crc_valid_out;

    // Stream source / result consumer side.
    modport master (
        output start_in, bit_in, bit_valid_in,
        input  bit_ready_out, busy_out, crc_out, crc_valid_out
    );

    // Accumulator side.
    modport slave (
        input  start_in, bit_in, bit_valid_in,
        output bit_ready_out, busy_out, crc_out, crc_valid_out
    );
endinterface

// File: rtl/serial_crc_accum_crc_lfsr_step.sv
// One combinational LFSR step of a Galois-form CRC: folds one data bit
// into the CRC register. Feedback taps are built from XOR cells.
//   crc_in     : current CRC register
//   bit_in     : incoming data bit
//   crc_next_c : CRC after absorbing bit_in (combinational)
module serial_crc_accum_crc_lfsr_step #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h07
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc_next_c
);
    logic             fb;
    logic [WIDTH-1:0] shifted;

    assign shifted = {crc_in[WIDTH-2:0], 1'b0};

    xor2_cell u_fb (
        .a (crc_in[WIDTH-1]),
        .b (bit_in),
        .y (fb)
    );

    // Only positions with a set polynomial bit get a feedback XOR cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_tap
        if (POLY[i]) begin : g_xor
            xor2_cell u_tap (
                .a (shifted[i]),
                .b (fb),
                .y (crc_next_c[i])
            );
        end else begin : g_pass
            assign crc_next_c[i] = shifted[i];
        end
    end
endmodule

// File: rtl/xor2_cell.sv
// Two-input XOR library cell.
//   a, b : inputs
//   y    : a ^ b
module xor2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_crc_accum.sv
// Bit-serial CRC accumulator. Accepts FRAME_LEN bits per frame through a
// valid/ready handshake, then pulses crc_valid_out for one cycle with the
// final CRC on crc_out.
//   clk_in : clock, rising edge
//   rst_in : synchronous active-high reset
//   bus    : stream/result interface (slave side)
module serial_crc_accum
    import serial_crc_accum_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY      = DEF_POLY,
    parameter logic [WIDTH-1:0] INIT      = DEF_INIT,
    parameter int unsigned      FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic              clk_in,
    input  logic              rst_in,
    serial_crc_accum_if.slave bus
);
    localparam int unsigned        CNT_W    = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, busy_q, valid_q;
    logic [WIDTH-1:0] crc_next_c;
    logic             accept_c;

    serial_crc_accum_crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc_in     (crc_q),
        .bit_in     (bus.bit_in),
        .crc_next_c (crc_next_c)
    );

    // ready_q is high exactly while in SHIFT.
    assign accept_c = ready_q && bus.bit_valid_in;

    // Next-state, CRC and counter logic.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    crc_d   = INIT;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (accept_c) begin
                    crc_d = crc_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; flags are decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_SHIFT);
            busy_q  <= (state_d != ST_IDLE);
            valid_q <= (state_d == ST_DONE);
        end
    end

    assign bus.bit_ready_out = ready_q;
    assign bus.busy_out      = busy_q;
    assign bus.crc_out       = crc_q;
    assign bus.crc_valid_out = valid_q;
endmodule

// File: tb/tb_serial_crc_accum.sv
module tb_serial_crc_accum;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_crc_accum_if #(.WIDTH(8)) if16 ();
    serial_crc_accum_if #(.WIDTH(8)) if72 ();

    serial_crc_accum #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .FRAME_LEN(16)) dut16 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if16.slave)
    );

    serial_crc_accum #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .FRAME_LEN(72)) dut72 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if72.slave)
    );

    int errors = 0;
    int checks = 0;
    int pulses16 = 0, pulses72 = 0;
    int exp16 = 0, exp72 = 0;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  crc;
    } vec_t;

    vec_t vt[6];

    // Count every crc_valid_out cycle seen on each instance.
    always @(negedge clk) begin
        if (if16.crc_valid_out === 1'b1) pulses16++;
        if (if72.crc_valid_out === 1'b1) pulses72++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1 (INIT=0),
    // computed by long division over a bit queue.
    function automatic logic [7:0] ref_crc(input logic [71:0] data, input int len);
        bit         m[$];
        logic [8:0] g;
        logic [7:0] r;
        g = 9'h107;
        for (int i = 0; i < len; i++) m.push_back(data[len-1-i]);
        for (int i = 0; i < 8; i++) m.push_back(1'b0);
        for (int i = 0; i < len; i++)
            if (m[i])
                for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ g[8-j];
        r = '0;
        for (int j = 0; j < 8; j++) r = {r[6:0], m[len+j]};
        return r;
    endfunction

    task automatic drive(input int sel, input logic s, input logic b, input logic v);
        if (sel == 72) begin
            if72.start_in = s; if72.bit_in = b; if72.bit_valid_in = v;
        end else begin
            if16.start_in = s; if16.bit_in = b; if16.bit_valid_in = v;
        end
    endtask

    function automatic logic [10:0] outs(input int sel);
        // {crc[7:0], ready, busy, crc_valid}
        if (sel == 72)
            return {if72.crc_out, if72.bit_ready_out, if72.busy_out, if72.crc_valid_out};
        return {if16.crc_out, if16.bit_ready_out, if16.busy_out, if16.crc_valid_out};
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the IDLE negedge
    // following the DONE cycle. hold keeps start_in high throughout.
    task automatic run_frame(input int sel, input logic [71:0] data, input int len,
                             input logic [7:0] exp, input int gap_pct, input logic hold,
                             input string name);
        int          i, cyc;
        logic        v, b;
        logic [10:0] o;
        drive(sel, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        o = outs(sel);
        check({name, ".start_busy"}, o[1], 1'b1);
        check({name, ".start_ready"}, o[2], 1'b1);
        check({name, ".start_crc"}, o[10:3], 8'h00);
        i = 0;
        cyc = 0;
        while (i < len && cyc < 3000) begin
            v = ($urandom_range(99) >= gap_pct);
            b = data[len-1-i];
            drive(sel, hold, b, v);
            @(negedge clk);
            cyc++;
            if (v) i++;
            o = outs(sel);
            if (i < len && (o[2] !== 1'b1 || o[0] !== 1'b0 || o[1] !== 1'b1))
                check({name, ".shift_flags"}, {29'd0, o[2:0]}, 32'b110);
        end
        if (cyc >= 3000) check({name, ".timeout"}, 32'd0, 32'd1);
        drive(sel, hold, 1'b0, 1'b0);
        o = outs(sel);
        check({name, ".done_valid"}, o[0], 1'b1);
        check({name, ".done_crc"}, o[10:3], exp);
        check({name, ".done_ready"}, o[2], 1'b0);
        check({name, ".done_busy"}, o[1], 1'b1);
        if (sel == 72) exp72++; else exp16++;
        @(negedge clk);
        o = outs(sel);
        check({name, ".idle_valid"}, o[0], 1'b0);
        check({name, ".idle_busy"}, o[1], 1'b0);
        check({name, ".idle_crc_hold"}, o[10:3], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] o;
        logic [15:0] rd;
        vt[0] = '{16'h0001, 8'h07};
        vt[1] = '{16'h0100, 8'h15};
        vt[2] = '{16'h0000, 8'h00};
        vt[3] = '{16'h0002, 8'h0E};
        vt[4] = '{16'h0003, 8'h09};
        vt[5] = '{16'h0007, 8'h15};

        rst = 1'b1;
        drive(16, 1'b0, 1'b0, 1'b0);
        drive(72, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle: bit_valid_in toggling must be ignored.
        for (int k = 0; k < 6; k++) begin
            drive(16, 1'b0, k[0], k[0]);
            @(negedge clk);
            o = outs(16);
            check("idle_crc", o[10:3], 8'h00);
            check("idle_flags", {29'd0, o[2:0]}, 32'd0);
        end
        drive(16, 1'b0, 1'b0, 1'b0);

        // Table vectors, valid always high.
        foreach (vt[k]) run_frame(16, {56'd0, vt[k].data}, 16, vt[k].crc, 0, 1'b0, $sformatf("vec%0d", k));

        // 0x0100 with random valid gaps.
        run_frame(16, 72'h0100, 16, 8'h15, 50, 1'b0, "gaps_0100");

        // 72-bit frame "123456789".
        run_frame(72, 72'h313233343536373839, 72, 8'hF4, 20, 1'b0, "ascii72");

        // Abort after 5 accepted bits.
        drive(16, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            drive(16, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
        end
        drive(16, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = outs(16);
        check("abort_crc", o[10:3], 8'h00);
        check("abort_flags", {29'd0, o[2:0]}, 32'd0);
        @(negedge clk);
        o = outs(16);
        check("abort_idle_flags", {29'd0, o[2:0]}, 32'd0);
        run_frame(16, 72'h0000, 16, 8'h00, 0, 1'b0, "after_abort");

        // start_in held high across two back-to-back frames.
        run_frame(16, 72'h0001, 16, 8'h07, 0, 1'b1, "hold1");
        run_frame(16, 72'h0001, 16, 8'h07, 0, 1'b1, "hold2");
        drive(16, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        o = outs(16);
        check("hold_end_busy", o[1], 1'b0);

        // Random frames against the reference model.
        for (int k = 0; k < 20; k++) begin
            rd = 16'($urandom);
            run_frame(16, {56'd0, rd}, 16, ref_crc({56'd0, rd}, 16), 30, 1'b0, $sformatf("rand%0d", k));
        end

        @(negedge clk);
        check("pulses16", pulses16, exp16);
        check("pulses72", pulses72, exp72);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
